stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control FSM and BCD time-keeping core for the stopwatch. Consumes the single-cycle debounced button pulses, the run/adjust switch levels, and the 1 Hz/2 Hz strobes from the clock divider.
- Sequences run/pause/adjust/clear and drives the MM:SS digit registers plus the blink enables for the 7-segment display driver.
- Sits between the button debouncers and the display multiplexer.

Parameters:
- MAX_MIN_TENS, 5, upper tens digit for minutes; minutes wrap after MAX_MIN_TENS*10+9.
- MAX_SEC_TENS, 5, upper tens digit for seconds; seconds wrap after MAX_SEC_TENS*10+9.

Ports:
- src_clk  input  1  system clock; all state updates on the rising edge.
- src_rst  input  1  synchronous, active-high reset.
- pause_btn  input  1  one-cycle debounced pulse; toggles run/pause.
- clr_btn  input  1  one-cycle debounced pulse; clears the time to 00:00.
- adj  input  1  level switch; 1 = adjust mode.
- sel  input  1  level switch; adjust target, 0 = minutes, 1 = seconds.
- tick_1hz  input  1  one-cycle strobe, 1 Hz.
- tick_2hz  input  1  one-cycle strobe, 2 Hz.
- min_tens  output  4  BCD minutes tens digit.
- min_ones  output  4  BCD minutes ones digit.
- sec_tens  output  4  BCD seconds tens digit.
- sec_ones  output  4  BCD seconds ones digit.
- running  output  1  1 while in RUN.
- blank_min  output  1  1 = display driver blanks the minute digits.
- blank_sec  output  1  1 = display driver blanks the second digits.

Behaviour:
- Reset (src_rst=1 at an edge): state=PAUSE, all digits=0, blink phase=0, running=0, blank_min=0, blank_sec=0. Reset overrides every other input.
- All outputs are registered. A digit change appears 1 cycle after the qualifying strobe.
- States are RUN, PAUSE and ADJUST. running = (state==RUN).
- Transition priority per cycle is adj, then pause_btn.
- adj=1 in RUN or PAUSE: go to ADJUST next cycle. A pause_btn in the same cycle is ignored.
- ADJUST with adj=0: go to PAUSE.
- PAUSE with pause_btn: go to RUN. RUN with pause_btn: go to PAUSE.
- pause_btn in ADJUST is ignored.
- RUN counting, on tick_1hz:
  - sec_ones increments; 9 -> 0 with carry into sec_tens.
  - sec_tens at MAX_SEC_TENS with sec_ones=9 -> 00 and carry into minutes.
  - Minutes follow the same rule with MAX_MIN_TENS; 59:59 -> 00:00 (full wrap, no flag).
- A tick_1hz in the same cycle as the RUN -> PAUSE transition is still counted, because the count uses the current state.
- PAUSE: digits hold; ticks are ignored.
- ADJUST: on tick_2hz, the field selected by sel increments by 1. It wraps 59 -> 00 with no carry into the other field. tick_1hz is ignored.
- A sel change takes effect at the next tick_2hz.
- clr_btn: in any state, all digits go to 0 next cycle and the state is unchanged. clr_btn takes priority over a same-cycle tick, so the result is 00:00, not 00:01. In RUN, counting resumes from 00:00 on the next tick_1hz.
- Blink phase:
  - Toggles on each tick_2hz while in ADJUST (1 Hz blink).
  - Forced to 0 in any other state and on entry to ADJUST.
  - blank_min = ADJUST & ~sel & phase.
  - blank_sec = ADJUST & sel & phase.
- Digits never leave the legal BCD range; the ones digit is never greater than 9 and the tens digit never greater than MAX_*_TENS.
- Reset mid-count or mid-adjust gives the reset values on the next cycle, regardless of pending strobes.

Test Plan:
- Reset, then 3 tick_1hz -> digits stay 00:00 and running=0. Then pause_btn and 3 tick_1hz -> 00:03, running=1.
- Preload 00:59 in RUN, tick_1hz -> 01:00. Preload 59:59, tick_1hz -> 00:00.
- RUN at 00:10, pause_btn and tick_1hz in the same cycle -> 00:11 and running=0. 5 further ticks -> holds 00:11.
- adj=1, sel=1 at 00:58, 3 tick_2hz -> 00:01 with minutes unchanged. blank_sec toggles 1,0,1 and blank_min stays 0. adj=0 -> PAUSE, blanks 0.
- RUN at 12:34, clr_btn and tick_1hz in the same cycle -> 00:00 with running=1. Next tick -> 00:01.
- In ADJUST with sel=0 at 05:00, assert src_rst together with tick_2hz -> 00:00, PAUSE, all blanks 0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM (RUN/PAUSE/ADJUST) with MM:SS BCD time-keeping
// and adjust-mode blink enables for the 7-segment driver.
module stopwatch_ctrl #(
   parameter int MAX_MIN_TENS = 5,
   parameter int MAX_SEC_TENS = 5
) (
   input  logic       src_clk,
   input  logic       src_rst,
   input  logic       pause_btn,
   input  logic       clr_btn,
   input  logic       adj,
   input  logic       sel,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       blank_min,
   output logic       blank_sec
);

   localparam logic [3:0] MIN_TMAX = 4'(MAX_MIN_TENS);
   localparam logic [3:0] SEC_TMAX = 4'(MAX_SEC_TENS);

   typedef enum logic [1:0] {
      ST_PAUSE  = 2'd0,
      ST_RUN    = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   state_t     state, state_n;
   logic       phase, phase_n;
   logic [3:0] min_tens_n, min_ones_n, sec_tens_n, sec_ones_n;

   // Incremented forms of each field; the wrap flags double as carries.
   logic       sec_wrap, min_wrap;
   logic [3:0] sec_tens_inc, sec_ones_inc, min_tens_inc, min_ones_inc;

   always_comb begin
      sec_wrap     = (sec_tens == SEC_TMAX) && (sec_ones == 4'd9);
      min_wrap     = (min_tens == MIN_TMAX) && (min_ones == 4'd9);
      sec_ones_inc = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
      sec_tens_inc = (sec_ones != 4'd9) ? sec_tens :
                     (sec_wrap ? 4'd0 : sec_tens + 4'd1);
      min_ones_inc = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
      min_tens_inc = (min_ones != 4'd9) ? min_tens :
                     (min_wrap ? 4'd0 : min_tens + 4'd1);
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_RUN: begin
            if (adj)            state_n = ST_ADJUST;
            else if (pause_btn) state_n = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (adj)            state_n = ST_ADJUST;
            else if (pause_btn) state_n = ST_RUN;
         end
         ST_ADJUST: begin
            if (!adj)           state_n = ST_PAUSE;
         end
         default:               state_n = ST_PAUSE;
      endcase
   end

   // Phase only runs while staying in ADJUST, so entry and exit both clear it.
   always_comb begin
      phase_n = 1'b0;
      if (state == ST_ADJUST && state_n == ST_ADJUST)
         phase_n = phase ^ tick_2hz;
   end

   // Counting keys off the current state, so a tick on the RUN->PAUSE edge still counts.
   always_comb begin
      min_tens_n = min_tens;
      min_ones_n = min_ones;
      sec_tens_n = sec_tens;
      sec_ones_n = sec_ones;
      if (clr_btn) begin
         min_tens_n = 4'd0;
         min_ones_n = 4'd0;
         sec_tens_n = 4'd0;
         sec_ones_n = 4'd0;
      end else if (state == ST_RUN && tick_1hz) begin
         sec_tens_n = sec_tens_inc;
         sec_ones_n = sec_ones_inc;
         if (sec_wrap) begin
            min_tens_n = min_tens_inc;
            min_ones_n = min_ones_inc;
         end
      end else if (state == ST_ADJUST && tick_2hz) begin
         if (sel) begin
            sec_tens_n = sec_tens_inc;
            sec_ones_n = sec_ones_inc;
         end else begin
            min_tens_n = min_tens_inc;
            min_ones_n = min_ones_inc;
         end
      end
   end

   always_ff @(posedge src_clk) begin
      if (src_rst) begin
         state     <= ST_PAUSE;
         phase     <= 1'b0;
         min_tens  <= 4'd0;
         min_ones  <= 4'd0;
         sec_tens  <= 4'd0;
         sec_ones  <= 4'd0;
         running   <= 1'b0;
         blank_min <= 1'b0;
         blank_sec <= 1'b0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         min_tens  <= min_tens_n;
         min_ones  <= min_ones_n;
         sec_tens  <= sec_tens_n;
         sec_ones  <= sec_ones_n;
         running   <= (state_n == ST_RUN);
         blank_min <= (state_n == ST_ADJUST) & ~sel & phase_n;
         blank_sec <= (state_n == ST_ADJUST) &  sel & phase_n;
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Table-driven bench for stopwatch_ctrl: per-cycle vectors feed an expected-
// value queue that is popped and compared one cycle after each drive.
module tb_stopwatch_ctrl;

   logic       src_clk = 1'b0;
   logic       src_rst, pause_btn, clr_btn, adj, sel, tick_1hz, tick_2hz;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, blank_min, blank_sec;

   always #5 src_clk = ~src_clk;

   stopwatch_ctrl #(.MAX_MIN_TENS(5), .MAX_SEC_TENS(5)) dut (
      .src_clk(src_clk), .src_rst(src_rst), .pause_btn(pause_btn),
      .clr_btn(clr_btn), .adj(adj), .sel(sel), .tick_1hz(tick_1hz),
      .tick_2hz(tick_2hz), .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones), .running(running),
      .blank_min(blank_min), .blank_sec(blank_sec)
   );

   typedef struct {
      string       name;
      logic        rst, pause, clr, adj, sel, t1, t2;
      logic [15:0] d;
      logic        run, bmin, bsec;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] d;
      logic        run, bmin, bsec;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [15:0] bcd(input int m, input int s);
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic void add(input string nm, input logic r, p, c, a, s, t1, t2,
                               input logic [15:0] d, input logic run, bm, bs);
      vec_t v;
      v.name = nm; v.rst = r; v.pause = p; v.clr = c; v.adj = a; v.sel = s;
      v.t1 = t1; v.t2 = t2; v.d = d; v.run = run; v.bmin = bm; v.bsec = bs;
      tbl.push_back(v);
   endfunction

   task automatic check1(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, got, want);
   endtask

   // Drive one cycle of inputs, queue its expectation, then compare after the edge.
   task automatic apply(input string nm, input logic r, p, c, a, s, t1, t2,
                        input logic [15:0] d, input logic run, bm, bs);
      exp_t e;
      @(negedge src_clk);
      src_rst = r; pause_btn = p; clr_btn = c; adj = a; sel = s;
      tick_1hz = t1; tick_2hz = t2;
      e.name = nm; e.d = d; e.run = run; e.bmin = bm; e.bsec = bs;
      exp_q.push_back(e);
      @(posedge src_clk);
      #1;
      e = exp_q.pop_front();
      check1({e.name, ".digits"}, {min_tens, min_ones, sec_tens, sec_ones}, e.d);
      check1({e.name, ".running"}, 16'(running), 16'(e.run));
      check1({e.name, ".blanks"}, 16'({blank_min, blank_sec}), 16'({e.bmin, e.bsec}));
   endtask

   // Load a time through ADJUST (clear + enter in one cycle), ending in PAUSE.
   task automatic set_time(input int m, input int s);
      apply("set_enter", 0, 0, 1, 1, 0, 0, 0, bcd(0, 0), 0, 0, 0);
      for (int i = 1; i <= m; i++)
         apply("set_min", 0, 0, 0, 1, 0, 0, 1, bcd(i, 0), 0, 1'(i % 2), 0);
      for (int j = 1; j <= s; j++)
         apply("set_sec", 0, 0, 0, 1, 1, 0, 1, bcd(m, j), 0, 0, 1'((m + j) % 2));
      apply("set_exit", 0, 0, 0, 0, 0, 0, 0, bcd(m, s), 0, 0, 0);
   endtask

   initial begin
      src_rst = 1'b1; pause_btn = 0; clr_btn = 0; adj = 0; sel = 0;
      tick_1hz = 0; tick_2hz = 0;

      //    name         rst p c a s t1 t2  digits      run bm bs
      add("reset",       1, 0,0,0,0,0,0, bcd(0,0),   0, 0,0);
      for (int i = 0; i < 3; i++)
         add("pause_tick", 0, 0,0,0,0,1,0, bcd(0,0), 0, 0,0);
      add("go_run",      0, 1,0,0,0,0,0, bcd(0,0),   1, 0,0);
      for (int i = 1; i <= 10; i++)
         add("run_tick",  0, 0,0,0,0,1,0, bcd(0,i), 1, 0,0);
      add("pause_edge",  0, 1,0,0,0,1,0, bcd(0,11),  0, 0,0);
      for (int i = 0; i < 5; i++)
         add("hold",      0, 0,0,0,0,1,0, bcd(0,11), 0, 0,0);
      add("adj_enter",   0, 0,0,1,1,0,0, bcd(0,11),  0, 0,0);
      add("adj_sec1",    0, 0,0,1,1,0,1, bcd(0,12),  0, 0,1);
      add("adj_sec2",    0, 0,0,1,1,0,1, bcd(0,13),  0, 0,0);
      add("adj_min1",    0, 0,0,1,0,0,1, bcd(1,13),  0, 1,0);
      add("adj_idle",    0, 0,0,1,0,0,0, bcd(1,13),  0, 1,0);
      add("adj_t1_ign",  0, 0,0,1,0,1,0, bcd(1,13),  0, 1,0);
      add("adj_exit",    0, 0,0,0,0,0,0, bcd(1,13),  0, 0,0);
      add("clr_pause",   0, 0,1,0,0,0,0, bcd(0,0),   0, 0,0);
      add("go_run2",     0, 1,0,0,0,0,0, bcd(0,0),   1, 0,0);
      add("run_tick2",   0, 0,0,0,0,1,0, bcd(0,1),   1, 0,0);
      add("adj_over_p",  0, 1,0,1,0,0,0, bcd(0,1),   0, 0,0);
      add("adj_p_ign",   0, 1,0,1,0,0,1, bcd(1,1),   0, 1,0);
      add("adj_exit2",   0, 0,0,0,0,0,0, bcd(1,1),   0, 0,0);
      add("go_run3",     0, 1,0,0,0,0,0, bcd(1,1),   1, 0,0);
      add("clr_tick",    0, 0,1,0,0,1,0, bcd(0,0),   1, 0,0);
      add("after_clr",   0, 0,0,0,0,1,0, bcd(0,1),   1, 0,0);

      foreach (tbl[k])
         apply(tbl[k].name, tbl[k].rst, tbl[k].pause, tbl[k].clr, tbl[k].adj,
               tbl[k].sel, tbl[k].t1, tbl[k].t2, tbl[k].d, tbl[k].run,
               tbl[k].bmin, tbl[k].bsec);

      // Seconds carry into minutes.
      set_time(0, 59);
      apply("run_059",   0, 1,0,0,0,0,0, bcd(0,59),  1, 0,0);
      apply("carry_100", 0, 0,0,0,0,1,0, bcd(1,0),   1, 0,0);

      // Full wrap 59:59 -> 00:00.
      set_time(59, 59);
      apply("run_5959",  0, 1,0,0,0,0,0, bcd(59,59), 1, 0,0);
      apply("wrap_0000", 0, 0,0,0,0,1,0, bcd(0,0),   1, 0,0);

      // Seconds field wraps in ADJUST without touching minutes; blink on seconds.
      set_time(0, 58);
      apply("a58_enter", 0, 0,0,1,1,0,0, bcd(0,58),  0, 0,0);
      apply("a58_t1",    0, 0,0,1,1,0,1, bcd(0,59),  0, 0,1);
      apply("a58_t2",    0, 0,0,1,1,0,1, bcd(0,0),   0, 0,0);
      apply("a58_t3",    0, 0,0,1,1,0,1, bcd(0,1),   0, 0,1);
      apply("a58_exit",  0, 0,0,0,1,0,0, bcd(0,1),   0, 0,0);

      // Clear beats a same-cycle tick in RUN.
      set_time(12, 34);
      apply("run_1234",  0, 1,0,0,0,0,0, bcd(12,34), 1, 0,0);
      apply("clr_win",   0, 0,1,0,0,1,0, bcd(0,0),   1, 0,0);
      apply("clr_next",  0, 0,0,0,0,1,0, bcd(0,1),   1, 0,0);

      // Reset mid-adjust with a pending strobe.
      set_time(5, 0);
      apply("a500_ent",  0, 0,0,1,0,0,0, bcd(5,0),   0, 0,0);
      apply("rst_adj",   1, 0,0,1,0,0,1, bcd(0,0),   0, 0,0);
      apply("post_rst",  0, 0,0,0,0,1,0, bcd(0,0),   0, 0,0);
      apply("rst_run",   0, 1,0,0,0,0,0, bcd(0,0),   1, 0,0);
      apply("rst_tick",  0, 0,0,0,0,1,0, bcd(0,1),   1, 0,0);

      @(negedge src_clk);
      pause_btn = 0; clr_btn = 0; adj = 0; sel = 0; tick_1hz = 0; tick_2hz = 0;
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL scoreboard: got %0d leftover want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
